// File: rtl/fetch.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, in-order response FIFO, redirect flush.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect target raises a sticky fault and halts fetch.
module fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_encoding,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never waits on ready, and payloads hold while valid & !ready.

  localparam int CW = 3;
  localparam int PW = (MAX_OUTSTANDING > 2) ? 2 : 1;
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_P = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, FAULT = 2'd2} state_e;

  state_e         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [CW-1:0]  out_q, out_d;
  logic [CW-1:0]  drop_q, drop_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [PW-1:0]  pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
  logic [31:0]    fifo_data_q [MAX_OUTSTANDING];
  logic [31:0]    fifo_data_d [MAX_OUTSTANDING];
  logic [31:0]    fifo_pc_q   [MAX_OUTSTANDING];
  logic [31:0]    fifo_pc_d   [MAX_OUTSTANDING];
  logic [31:0]    pcq_q       [MAX_OUTSTANDING];
  logic [31:0]    pcq_d       [MAX_OUTSTANDING];
  logic           fault_q, fault_d;

  logic           misalign;
  logic           pop, push, accept;
  logic [CW:0]    used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = |redirect_pc[1:0];
`else
  assign misalign = 1'b0;
`endif

  assign inst_valid     = (cnt_q != '0) && (state_q != FAULT);
  assign pop            = inst_valid && inst_ready;
  // Credits count both in-flight requests and buffered words, so the FIFO cannot overflow.
  assign used           = {1'b0, out_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
  assign imem_req_valid = !rst && (state_q == RUN) && !redirect_valid && (used < {1'b0, MAX_C});
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = imem_resp_valid && (state_q == RUN) && !redirect_valid;

  assign imem_req_addr  = pc_q;
  assign inst_encoding  = fifo_data_q[rd_q];
  assign inst_pc        = fifo_pc_q[rd_q];
  assign fetch_fault    = fault_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    pq_rd_d     = pq_rd_q;
    pq_wr_d     = pq_wr_q;
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;
    pcq_d       = pcq_q;
    fault_d     = fault_q;

    // The PC queue mirrors every in-flight request, whatever state its response lands in.
    if (accept) begin
      pcq_d[pq_wr_q] = pc_q;
      pq_wr_d        = ptr_inc(pq_wr_q);
      pc_d           = pc_q + 32'd4;
    end
    if (imem_resp_valid) pq_rd_d = ptr_inc(pq_rd_q);
    out_d = out_q + CW'(accept) - CW'(imem_resp_valid);

    if (push) begin
      fifo_data_d[wr_q] = imem_resp_data;
      fifo_pc_d[wr_q]   = pcq_q[pq_rd_q];
      wr_d              = ptr_inc(wr_q);
    end
    if (pop) rd_d = ptr_inc(rd_q);
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    case (state_q)
      RUN:   state_d = RUN;
      FLUSH: begin
        if (imem_resp_valid) begin
          drop_d = drop_q - 1'b1;
          if (drop_q == CW'(1)) state_d = RUN;
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = RUN;
    endcase

    // In FLUSH the FIFO is already empty and drop equals outstanding, so this only moves the PC there.
    if (redirect_valid && (state_q != FAULT)) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      cnt_d   = '0;
      rd_d    = '0;
      wr_d    = '0;
      drop_d  = out_q - CW'(imem_resp_valid);
      state_d = (drop_d != '0) ? FLUSH : RUN;
      if (misalign) begin
        state_d = FAULT;
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      pq_rd_q <= '0;
      pq_wr_q <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
        pcq_q[i]       <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      pq_rd_q     <= pq_rd_d;
      pq_wr_q     <= pq_wr_d;
      fault_q     <= fault_d;
      fifo_data_q <= fifo_data_d;
      fifo_pc_q   <= fifo_pc_d;
      pcq_q       <= pcq_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: RESET_PC=0x100, two credits, an in-order memory model with settable latency.
// Delivered instructions are checked against an expected-PC queue; encodings are a fixed function of the address.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_encoding;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  fetch #(.RESET_PC(32'h0000_0100), .MAX_OUTSTANDING(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_encoding   (inst_encoding),
    .inst_pc         (inst_pc),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;

  logic [31:0] exp_q[$];
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  logic        s_req_valid, s_inst_valid, s_fault;
  logic [31:0] s_req_addr, s_inst_pc, s_inst_enc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, update the scoreboard and memory, then drive responses after the rise.
  task automatic cycle();
    logic [31:0] e;
    @(negedge clk);
    s_req_valid  = imem_req_valid;
    s_req_addr   = imem_req_addr;
    s_inst_valid = inst_valid;
    s_inst_pc    = inst_pc;
    s_inst_enc   = inst_encoding;
    s_fault      = fetch_fault;
    if (!rst && imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + mem_lat);
    end
    if (!rst && inst_valid && inst_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_inst: observed pc %h expected no delivery", inst_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_inst_pc", inst_pc, e);
        chk("sb_inst_encoding", inst_encoding, mem_word(e));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end else if (mq_due.size() != 0 && mq_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s: observed %0d pending expected 0 after %0d cycles", tag, exp_q.size(), budget);
    end
  endtask

  initial begin
    rst             = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    inst_ready      = 1'b1;

    // Reset values
    repeat (3) cycle();
    chk("rst_req_valid", s_req_valid, 0);
    chk("rst_req_addr", s_req_addr, 32'h100);
    chk("rst_inst_valid", s_inst_valid, 0);
    chk("rst_inst_encoding", s_inst_enc, 0);
    chk("rst_inst_pc", s_inst_pc, 0);
    chk("rst_fetch_fault", s_fault, 0);

    // Streaming with 1-cycle memory, then imem_req_ready low for 3 cycles
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    rst = 1'b0;
    cycle();
    chk("c0_req_valid", s_req_valid, 1);
    chk("c0_req_addr", s_req_addr, 32'h100);
    chk("c0_inst_valid", s_inst_valid, 0);
    cycle();
    chk("c1_req_addr", s_req_addr, 32'h104);
    chk("c1_inst_valid", s_inst_valid, 0);
    cycle();
    chk("c2_req_addr", s_req_addr, 32'h108);
    chk("c2_inst_valid", s_inst_valid, 1);
    chk("c2_inst_pc", s_inst_pc, 32'h100);
    cycle();
    chk("c3_req_addr", s_req_addr, 32'h10C);
    chk("c3_inst_pc", s_inst_pc, 32'h104);
    cycle();
    chk("c4_req_addr", s_req_addr, 32'h110);
    chk("c4_inst_pc", s_inst_pc, 32'h108);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_req_valid", s_req_valid, 1);
      chk("stall_req_addr", s_req_addr, 32'h114);
    end
    imem_req_ready = 1'b1;
    drain("drain_stream", 20);

    // Decode back-pressure: FIFO fills, requests stop, head holds
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_req_valid", s_req_valid, 0);
      chk("bp_inst_valid", s_inst_valid, 1);
      chk("bp_inst_pc", s_inst_pc, 32'h120);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h120 + 32'(4 * i));
    inst_ready = 1'b1;
    drain("drain_backpressure", 20);

    // Build two outstanding requests with 3-cycle memory, then redirect to 0x200
    inst_ready = 1'b0;
    mem_lat    = 3;
    cycle();
    chk("full_req_valid", s_req_valid, 0);
    exp_q.push_back(32'h130);
    exp_q.push_back(32'h134);
    inst_ready = 1'b1;
    drain("drain_pre_redirect", 10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cycle();
    chk("redir_req_valid", s_req_valid, 0);
    chk("redir_inst_valid", s_inst_valid, 0);
    redirect_valid = 1'b0;
    cycle();
    chk("flush1_req_valid", s_req_valid, 0);
    chk("flush1_inst_valid", s_inst_valid, 0);
    cycle();
    chk("flush2_req_valid", s_req_valid, 0);
    cycle();
    chk("post_flush_req_valid", s_req_valid, 1);
    chk("post_flush_req_addr", s_req_addr, 32'h200);
    mem_lat = 1;
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    drain("drain_after_redirect", 20);

    // Redirect in the same cycle as a response and a pop
    exp_q.push_back(32'h208);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    cycle();
    chk("same_cycle_req_valid", s_req_valid, 0);
    chk("same_cycle_inst_pc", s_inst_pc, 32'h208);
    redirect_valid = 1'b0;
    exp_q.push_back(32'h300);
    cycle();
    chk("same_cycle_next_inst_valid", s_inst_valid, 0);
    chk("same_cycle_next_req_addr", s_req_addr, 32'h300);
    drain("drain_same_cycle", 20);

    // Misaligned redirect target
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h202;
    cycle();
    chk("misalign_redir_req_valid", s_req_valid, 0);
    redirect_valid = 1'b0;
    cycle();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("fault_flag", s_fault, 1);
    chk("fault_req_valid", s_req_valid, 0);
    chk("fault_inst_valid", s_inst_valid, 0);
    repeat (3) cycle();
    chk("fault_sticky", s_fault, 1);
    chk("fault_req_valid_held", s_req_valid, 0);
`else
    chk("nofault_flag", s_fault, 0);
    chk("nofault_req_valid", s_req_valid, 1);
    chk("nofault_req_addr", s_req_addr, 32'h200);
    exp_q.push_back(32'h200);
    inst_ready = 1'b1;
    drain("drain_misalign", 10);
    inst_ready = 1'b0;
`endif

    // Mid-operation reset
    rst = 1'b1;
    repeat (2) cycle();
    chk("rst2_req_valid", s_req_valid, 0);
    chk("rst2_req_addr", s_req_addr, 32'h100);
    chk("rst2_inst_valid", s_inst_valid, 0);
    chk("rst2_inst_encoding", s_inst_enc, 0);
    chk("rst2_inst_pc", s_inst_pc, 0);
    chk("rst2_fetch_fault", s_fault, 0);
    rst = 1'b0;
    cycle();
    chk("rst2_first_req_valid", s_req_valid, 1);
    chk("rst2_first_req_addr", s_req_addr, 32'h100);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL final_exp_q: observed %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
